// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decode with HI/LO multiply interlock (optional ALU_CTRL_ILLEGAL_TRAP_EN)
package alu_pkg;
  typedef enum logic [4:0] {
    C_ADD_U = 5'd0, C_SUB_U = 5'd1, C_MULT = 5'd2, C_MUL_U = 5'd3,
    C_AND = 5'd4, C_OR = 5'd5, C_XOR = 5'd6, C_SRL = 5'd7,
    C_SLL = 5'd8, C_SRA = 5'd9, C_SLT = 5'd10, C_SLTU = 5'd11,
    C_MFHI = 5'd12, C_MFLO = 5'd13, C_JR = 5'd14, C_BEQ = 5'd15,
    C_BNE = 5'd16, C_BLEZ = 5'd17, C_BGTZ = 5'd18, C_BLTZ = 5'd19,
    C_BGEZ = 5'd20
  } alu_sel_t;
  typedef enum logic [5:0] {
    F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08,
    F_MFHI = 6'h10, F_MFLO = 6'h12, F_MULT = 6'h18, F_MUL_U = 6'h19,
    F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25,
    F_XOR = 6'h26, F_SLT = 6'h2a, F_SLTU = 6'h2b
  } r_sel_t;
endpackage

module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] ir_opcode,
  input  logic [5:0] ir_funct,
  input  logic [4:0] ir_rt,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] alu_sel,
  output logic       hilo_wr,
  output logic       illegal
);
  typedef enum logic {RUN, MUL_BUSY} state_t;
  state_t   state, state_n;
  logic [3:0] cnt, cnt_n;
  alu_sel_t dec_sel;
  logic     dec_ok, dec_mul, dec_hilo, stall, accept, word_ok;
  // instruction fields to ALU operation; unlisted encodings fall back to C_ADD_U
  always_comb begin
    dec_sel = C_ADD_U;
    dec_ok = 1'b1;
    case (ir_opcode)
      6'b000000:
        case (ir_funct)
          F_ADDU:  dec_sel = C_ADD_U;
          F_SUBU:  dec_sel = C_SUB_U;
          F_MULT:  dec_sel = C_MULT;
          F_MUL_U: dec_sel = C_MUL_U;
          F_AND:   dec_sel = C_AND;
          F_OR:    dec_sel = C_OR;
          F_XOR:   dec_sel = C_XOR;
          F_SRL:   dec_sel = C_SRL;
          F_SLL:   dec_sel = C_SLL;
          F_SRA:   dec_sel = C_SRA;
          F_SLT:   dec_sel = C_SLT;
          F_SLTU:  dec_sel = C_SLTU;
          F_MFHI:  dec_sel = C_MFHI;
          F_MFLO:  dec_sel = C_MFLO;
          F_JR:    dec_sel = C_JR;
          default: dec_ok = 1'b0;
        endcase
      6'b000001: begin
        dec_sel = ir_rt == 5'd0 ? C_BLTZ : ir_rt == 5'd1 ? C_BGEZ : C_ADD_U;
        dec_ok = ir_rt[4:1] == 4'd0;
      end
      6'b001001, 6'b100011, 6'b101011, 6'b000010, 6'b000011: dec_sel = C_ADD_U;
      6'b001100: dec_sel = C_AND;
      6'b001101: dec_sel = C_OR;
      6'b001110: dec_sel = C_XOR;
      6'b001010: dec_sel = C_SLT;
      6'b001011: dec_sel = C_SLTU;
      6'b000100: dec_sel = C_BEQ;
      6'b000101: dec_sel = C_BNE;
      6'b000110: dec_sel = C_BLEZ;
      6'b000111: dec_sel = C_BGTZ;
      default:   dec_ok = 1'b0;
    endcase
  end
  assign dec_mul  = dec_sel == C_MULT || dec_sel == C_MUL_U;
  assign dec_hilo = dec_mul || dec_sel == C_MFHI || dec_sel == C_MFLO;
  assign stall    = state == MUL_BUSY && dec_hilo;
  assign in_ready = (!out_valid || out_ready) && !stall;
  assign accept   = in_valid && in_ready;
  // interlock state and busy counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt <= 4'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  // busy window opens on an accepted multiply and closes when the counter drains to 0
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (state == RUN) begin
      cnt_n = (accept && dec_mul) ? 4'(MUL_LAT) : cnt;
      state_n = (accept && dec_mul && MUL_LAT != 0) ? MUL_BUSY : RUN;
    end else begin
      cnt_n = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
      state_n = cnt_n == 4'd0 ? RUN : MUL_BUSY;
    end
  end
  // output stage: load on accept, hold while stalled downstream, drop after consume
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_sel <= C_ADD_U;
      hilo_wr <= 1'b0;
    end else if (accept) begin
      out_valid <= word_ok;
      alu_sel <= dec_sel;
      hilo_wr <= dec_mul;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  assign word_ok = dec_ok;
  // sticky flag for an accepted unsupported encoding, which emits no word
  always_ff @(posedge clk) begin
    if (rst) illegal <= 1'b0;
    else if (accept && !dec_ok) illegal <= 1'b1;
  end
`else
  logic unused_ok;
  assign unused_ok = dec_ok;
  assign word_ok = 1'b1;
  assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed plus random stimulus checked against a slot/timestamp reference model
module tb_alu_ctrl_seq;
  localparam int LAT = 4;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [5:0] ir_opcode = '0, ir_funct = '0;
  logic [4:0] ir_rt = '0;
  logic in_ready, out_valid, hilo_wr, illegal;
  logic [4:0] alu_sel;
  int checks = 0, passed = 0, fails = 0, cyc = 0, busy_until = 0;
  bit mo_valid = 0, mo_hilo = 0, mo_illegal = 0;
  logic [4:0] mo_sel = '0;
  logic [16:0] pool [0:30];

  alu_ctrl_seq #(.MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ir_opcode(ir_opcode), .ir_funct(ir_funct), .ir_rt(ir_rt),
    .out_valid(out_valid), .out_ready(out_ready), .alu_sel(alu_sel),
    .hilo_wr(hilo_wr), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void ref_dec(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                                  output bit ok, output logic [4:0] s);
    ok = 1;
    s = 5'd0;
    if (op == 6'h00) begin
      case (fn)
        6'h21: s = 5'd0;   6'h23: s = 5'd1;   6'h18: s = 5'd2;   6'h19: s = 5'd3;
        6'h24: s = 5'd4;   6'h25: s = 5'd5;   6'h26: s = 5'd6;   6'h02: s = 5'd7;
        6'h00: s = 5'd8;   6'h03: s = 5'd9;   6'h2a: s = 5'd10;  6'h2b: s = 5'd11;
        6'h10: s = 5'd12;  6'h12: s = 5'd13;  6'h08: s = 5'd14;
        default: ok = 0;
      endcase
    end else if (op == 6'h01) begin
      ok = rt < 5'd2;
      s = rt == 5'd0 ? 5'd19 : rt == 5'd1 ? 5'd20 : 5'd0;
    end else begin
      case (op)
        6'h09, 6'h23, 6'h2b, 6'h02, 6'h03: s = 5'd0;
        6'h0c: s = 5'd4;   6'h0d: s = 5'd5;   6'h0e: s = 5'd6;   6'h0a: s = 5'd10;
        6'h0b: s = 5'd11;  6'h04: s = 5'd15;  6'h05: s = 5'd16;  6'h06: s = 5'd17;
        6'h07: s = 5'd18;
        default: ok = 0;
      endcase
    end
  endfunction

  task automatic step(input bit v, input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] rt, input bit ordy);
    bit ok, mul, hl, rdy;
    logic [4:0] s;
    in_valid = v;
    ir_opcode = op;
    ir_funct = fn;
    ir_rt = rt;
    out_ready = ordy;
    #1;
    ref_dec(op, fn, rt, ok, s);
    mul = ok && (s == 5'd2 || s == 5'd3);
    hl = mul || (ok && (s == 5'd12 || s == 5'd13));
    rdy = (!mo_valid || ordy) && !(hl && cyc < busy_until);
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, mo_valid);
    if (mo_valid) begin
      chk("alu_sel", alu_sel, mo_sel);
      chk("hilo_wr", hilo_wr, mo_hilo);
    end
    chk("illegal", illegal, mo_illegal);
    if (v && rdy) begin
      mo_valid = 1;
      mo_sel = s;
      mo_hilo = mul;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      if (!ok) begin
        mo_valid = 0;
        mo_illegal = 1;
      end
`endif
      if (mul) busy_until = cyc + LAT + 1;
    end else if (ordy) begin
      mo_valid = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    in_valid = 0;
    rst = 1;
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rst = 0;
    mo_valid = 0;
    mo_illegal = 0;
    busy_until = 0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_alu_sel", alu_sel, 5'd0);
    chk("rst_hilo_wr", hilo_wr, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
  endtask

  initial begin
    pool = '{
      {6'h00, 6'h21, 5'd0}, {6'h00, 6'h23, 5'd0}, {6'h00, 6'h18, 5'd0}, {6'h00, 6'h19, 5'd0},
      {6'h00, 6'h24, 5'd0}, {6'h00, 6'h25, 5'd0}, {6'h00, 6'h26, 5'd0}, {6'h00, 6'h02, 5'd0},
      {6'h00, 6'h00, 5'd0}, {6'h00, 6'h03, 5'd0}, {6'h00, 6'h2a, 5'd0}, {6'h00, 6'h2b, 5'd0},
      {6'h00, 6'h10, 5'd0}, {6'h00, 6'h12, 5'd0}, {6'h00, 6'h08, 5'd0}, {6'h09, 6'h00, 5'd0},
      {6'h23, 6'h00, 5'd0}, {6'h2b, 6'h00, 5'd0}, {6'h02, 6'h00, 5'd0}, {6'h03, 6'h00, 5'd0},
      {6'h0c, 6'h00, 5'd0}, {6'h0d, 6'h00, 5'd0}, {6'h0e, 6'h00, 5'd0}, {6'h0a, 6'h00, 5'd0},
      {6'h0b, 6'h00, 5'd0}, {6'h04, 6'h00, 5'd0}, {6'h05, 6'h00, 5'd0}, {6'h06, 6'h00, 5'd0},
      {6'h07, 6'h00, 5'd0}, {6'h01, 6'h00, 5'd0}, {6'h01, 6'h00, 5'd1}
    };
    do_reset(2);
    step(1, 6'h00, 6'h21, 5'd0, 1);
    step(0, 6'h00, 6'h00, 5'd0, 1);
    step(1, 6'h0c, 6'h00, 5'd0, 1);
    step(1, 6'h0d, 6'h00, 5'd0, 1);
    step(1, 6'h04, 6'h00, 5'd0, 1);
    step(0, 6'h00, 6'h00, 5'd0, 1);
    step(0, 6'h00, 6'h00, 5'd0, 1);
    step(1, 6'h00, 6'h2a, 5'd0, 1);
    repeat (3) step(1, 6'h00, 6'h03, 5'd0, 0);
    step(1, 6'h00, 6'h03, 5'd0, 1);
    step(0, 6'h00, 6'h00, 5'd0, 1);
    step(0, 6'h00, 6'h00, 5'd0, 1);
    step(1, 6'h00, 6'h18, 5'd0, 1);
    repeat (5) step(1, 6'h00, 6'h10, 5'd0, 1);
    step(0, 6'h00, 6'h00, 5'd0, 1);
    step(0, 6'h00, 6'h00, 5'd0, 1);
    step(1, 6'h00, 6'h18, 5'd0, 1);
    step(1, 6'h00, 6'h21, 5'd0, 1);
    step(1, 6'h00, 6'h19, 5'd0, 1);
    repeat (6) step(1, 6'h00, 6'h19, 5'd0, 1);
    repeat (5) step(0, 6'h00, 6'h00, 5'd0, 1);
    step(1, 6'h01, 6'h00, 5'd1, 1);
    step(1, 6'h01, 6'h00, 5'd0, 1);
    step(1, 6'h01, 6'h00, 5'd2, 1);
    step(0, 6'h00, 6'h00, 5'd0, 1);
    step(1, 6'h00, 6'h18, 5'd0, 0);
    step(0, 6'h00, 6'h00, 5'd0, 0);
    step(0, 6'h00, 6'h00, 5'd0, 0);
    do_reset(1);
    step(1, 6'h00, 6'h12, 5'd0, 1);
    step(0, 6'h00, 6'h00, 5'd0, 1);
    for (int i = 0; i < 600; i++) begin
      logic [16:0] e;
      logic [5:0] op, fn;
      logic [4:0] rt;
      e = pool[$urandom_range(0, 30)];
      op = e[16:11];
      fn = op == 6'h00 ? e[10:5] : 6'($urandom);
      rt = op == 6'h01 ? e[4:0] : 5'($urandom);
      if ($urandom_range(0, 9) < 2) fn = 6'h18 + 6'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 2) {op, fn, rt} = 17'($urandom);
      if ($urandom_range(0, 9) < 3) op = 6'h00;
      step($urandom_range(0, 3) != 0, op, fn, rt, $urandom_range(0, 3) != 0);
      if (i == 300) do_reset(1);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
